// File: rtl/attn_pkg.sv
// rtl/attn_pkg.sv - shared instruction-word layout and sequencer state encoding
package attn_pkg;

  // fullchip instruction word layout
  localparam int INST_W          = 20;
  localparam int INST_SFP_PMEM_WR = 19;
  localparam int INST_ACC        = 18;
  localparam int INST_DIV        = 17;
  localparam int INST_OFIFO_RD   = 16;
  localparam int QKADD_LSB       = 12;
  localparam int PADD_LSB        = 8;
  localparam int INST_EXECUTE    = 7;
  localparam int INST_LOAD       = 6;
  localparam int INST_QMEM_RD    = 5;
  localparam int INST_QMEM_WR    = 4;
  localparam int INST_KMEM_RD    = 3;
  localparam int INST_KMEM_WR    = 2;
  localparam int INST_PMEM_RD    = 1;
  localparam int INST_PMEM_WR    = 0;

  typedef enum logic [3:0] {
    IDLE,
    KLOAD,
    KTAIL,
    GAP,
    EXEC,
    EDRAIN,
    MOVE,
    NORM,
    DONE
  } state_t;

  // Largest of three values; used to size the shared step counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/attn_seq_ctrl.sv
// rtl/attn_seq_ctrl.sv - instruction sequencer for the dual-core attention datapath
module attn_seq_ctrl
  import attn_pkg::*;
#(
  parameter int COL   = 8,   // K vectors loaded, 1..15
  parameter int N_Q   = 8,   // Q vectors executed/normalized, 1..16
  parameter int DRAIN = 10   // idle cycles after K load and after execute
) (
  input  logic        i_clk,
  input  logic        i_reset,        // asynchronous, active-low
  input  logic        i_start,
  input  logic        i_host_qmem_wr,
  input  logic        i_host_kmem_wr,
  input  logic [3:0]  i_host_add,
  input  logic        i_ofifo_valid,
  output logic [19:0] o_inst,
  output logic        o_busy,
  output logic        o_done
);

  // One counter serves every stepped phase, so it must hold the longest one.
  localparam int STEP_MAX = max3(COL + 1, DRAIN, N_Q);
  localparam int STEP_W   = $clog2(STEP_MAX + 1);

  localparam logic [STEP_W-1:0] C_ONE        = {{(STEP_W-1){1'b0}}, 1'b1};
  localparam logic [STEP_W-1:0] C_COL        = STEP_W'(COL);
  localparam logic [STEP_W-1:0] C_DRAIN_LAST = STEP_W'(DRAIN - 1);
  localparam logic [STEP_W-1:0] C_NQ_LAST    = STEP_W'(N_Q - 1);
  localparam logic [3:0]        C_ROW_LAST   = 4'(N_Q - 1);

  if (COL < 1 || COL > 15 || N_Q < 1 || N_Q > 16 || DRAIN < 1 || DRAIN > 1023) begin : g_param_check
    $error("attn_seq_ctrl: COL must be 1..15, N_Q 1..16, DRAIN 1..1023");
  end

  state_t              r_state;
  logic [STEP_W-1:0]   r_step;
  logic [3:0]          r_row;
  logic [1:0]          r_sub;
  logic [INST_W-1:0]   r_inst;
  logic                r_busy;
  logic                r_done;

  state_t              w_state_nxt;
  logic [STEP_W-1:0]   w_step_nxt;
  logic [3:0]          w_row_nxt;
  logic [1:0]          w_sub_nxt;
  logic [INST_W-1:0]   w_inst_nxt;
  logic                w_host_wr;
  logic [3:0]          w_step_add;
  logic [3:0]          w_step_add_m1;
  logic                w_move_beat;

  assign w_host_wr = i_host_qmem_wr | i_host_kmem_wr;

  // Next-state and counter update; a host write in IDLE pre-empts start.
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_row_nxt   = r_row;
    w_sub_nxt   = r_sub;
    case (r_state)
      IDLE: begin
        if (i_start && !w_host_wr) begin
          w_state_nxt = KLOAD;
          w_step_nxt  = '0;
        end
      end
      KLOAD: begin
        if (r_step == C_COL) begin
          w_state_nxt = KTAIL;
          w_step_nxt  = '0;
        end else begin
          w_step_nxt = r_step + C_ONE;
        end
      end
      KTAIL: begin
        w_state_nxt = GAP;
        w_step_nxt  = '0;
      end
      GAP: begin
        if (r_step == C_DRAIN_LAST) begin
          w_state_nxt = EXEC;
          w_step_nxt  = '0;
        end else begin
          w_step_nxt = r_step + C_ONE;
        end
      end
      EXEC: begin
        if (r_step == C_NQ_LAST) begin
          w_state_nxt = EDRAIN;
          w_step_nxt  = '0;
        end else begin
          w_step_nxt = r_step + C_ONE;
        end
      end
      EDRAIN: begin
        if (r_step == C_DRAIN_LAST) begin
          w_state_nxt = MOVE;
          w_step_nxt  = '0;
        end else begin
          w_step_nxt = r_step + C_ONE;
        end
      end
      MOVE: begin
        // r_step counts accepted beats; an empty ofifo simply holds here.
        if (i_ofifo_valid) begin
          if (r_step == C_NQ_LAST) begin
            w_state_nxt = NORM;
            w_step_nxt  = '0;
            w_row_nxt   = '0;
            w_sub_nxt   = '0;
          end else begin
            w_step_nxt = r_step + C_ONE;
          end
        end
      end
      NORM: begin
        w_sub_nxt = r_sub + 2'd1;
        if (r_sub == 2'd3) begin
          if (r_row == C_ROW_LAST) begin
            w_state_nxt = DONE;
            w_row_nxt   = '0;
          end else begin
            w_row_nxt = r_row + 4'd1;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_step_add    = 4'(w_step_nxt);
  assign w_step_add_m1 = (w_step_nxt <= C_ONE) ? 4'd0 : 4'(w_step_nxt - C_ONE);

  // Instruction word for the upcoming cycle, derived from the next state so it can be registered.
  always_comb begin
    w_inst_nxt = '0;
    case (w_state_nxt)
      IDLE: begin
        // Host forwarding only from a settled IDLE; the DONE->IDLE cycle stays quiet.
        if (r_state == IDLE) begin
          w_inst_nxt[INST_QMEM_WR]        = i_host_qmem_wr;
          w_inst_nxt[INST_KMEM_WR]        = i_host_kmem_wr;
          w_inst_nxt[QKADD_LSB +: 4]      = i_host_add;
        end
      end
      KLOAD: begin
        w_inst_nxt[INST_LOAD]           = 1'b1;
        w_inst_nxt[INST_KMEM_RD]        = (w_step_nxt != '0);
        w_inst_nxt[QKADD_LSB +: 4]      = w_step_add_m1;
      end
      KTAIL: begin
        w_inst_nxt[INST_LOAD]           = 1'b1;
      end
      EXEC: begin
        w_inst_nxt[INST_EXECUTE]        = 1'b1;
        w_inst_nxt[INST_QMEM_RD]        = 1'b1;
        w_inst_nxt[QKADD_LSB +: 4]      = w_step_add;
      end
      MOVE: begin
        w_inst_nxt[PADD_LSB +: 4]       = w_step_add;
      end
      NORM: begin
        w_inst_nxt[PADD_LSB +: 4]       = w_row_nxt;
        case (w_sub_nxt)
          2'd0: begin
            w_inst_nxt[INST_PMEM_RD]    = 1'b1;
            w_inst_nxt[INST_ACC]        = 1'b1;
          end
          2'd2: begin
            w_inst_nxt[INST_DIV]        = 1'b1;
          end
          2'd3: begin
            w_inst_nxt[INST_SFP_PMEM_WR] = 1'b1;
            w_inst_nxt[INST_PMEM_WR]    = 1'b1;
          end
          default: begin
            w_inst_nxt = w_inst_nxt;
          end
        endcase
      end
      default: begin
        w_inst_nxt = '0;
      end
    endcase
  end

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
      r_step  <= '0;
      r_row   <= '0;
      r_sub   <= '0;
      r_inst  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_row   <= w_row_nxt;
      r_sub   <= w_sub_nxt;
      r_inst  <= w_inst_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= (w_state_nxt == DONE);
    end
  end

  // The ofifo pop and pmem write follow ofifo_valid in the same cycle so no beat is lost.
  assign w_move_beat = (r_state == MOVE) && i_ofifo_valid;

  assign o_inst = r_inst | {3'b000, w_move_beat, 15'd0, w_move_beat};
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_attn_seq_ctrl.sv
// tb/tb_attn_seq_ctrl.sv - self-checking bench for attn_seq_ctrl
module tb_attn_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        start_s;
  logic        qwr;
  logic        kwr;
  logic [3:0]  hadd;
  logic        ofv;
  logic [19:0] inst;
  logic [19:0] inst_s;
  logic        busy;
  logic        busy_s;
  logic        done;
  logic        done_s;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          ofv;
    bit          inj;
    logic [19:0] inst;
    bit          done;
  } rec_t;

  typedef struct {
    logic        q;
    logic        k;
    logic [3:0]  a;
    logic        st;
    logic [19:0] inst;
    logic        busy;
  } vec_t;

  rec_t exp_q[$];
  vec_t vecs[6];

  always #5 clk = ~clk;

  attn_seq_ctrl dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_start        (start),
    .i_host_qmem_wr (qwr),
    .i_host_kmem_wr (kwr),
    .i_host_add     (hadd),
    .i_ofifo_valid  (ofv),
    .o_inst         (inst),
    .o_busy         (busy),
    .o_done         (done)
  );

  attn_seq_ctrl #(.COL(4), .N_Q(2), .DRAIN(1)) dut_s (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_start        (start_s),
    .i_host_qmem_wr (1'b0),
    .i_host_kmem_wr (1'b0),
    .i_host_add     (4'd0),
    .i_ofifo_valid  (1'b1),
    .o_inst         (inst_s),
    .o_busy         (busy_s),
    .o_done         (done_s)
  );

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic push(input int w, input bit v, input bit j, input bit d);
    rec_t r;
    r.ofv  = v;
    r.inj  = j;
    r.inst = 20'(w);
    r.done = d;
    exp_q.push_back(r);
  endtask

  // Expected per-cycle trace of one run, written phase by phase.
  task automatic build(input int col, input int nq, input int dr,
                       input int st_after, input int st_len, input bit inj);
    exp_q.delete();
    for (int s = 0; s <= col; s++)
      push('h40 + ((s >= 1) ? 'h8 : 0) + (((s <= 1) ? 0 : (s - 1)) << 12), 1'b1, 1'b0, 1'b0);
    push('h40, 1'b1, 1'b0, 1'b0);
    for (int g = 0; g < dr; g++)
      push(0, 1'b1, inj && (g == 2), 1'b0);
    for (int s = 0; s < nq; s++)
      push('h80 + 'h20 + (s << 12), 1'b1, 1'b0, 1'b0);
    for (int g = 0; g < dr; g++)
      push(0, 1'b1, 1'b0, 1'b0);
    for (int b = 0; b < nq; b++) begin
      if (b == st_after)
        for (int i = 0; i < st_len; i++)
          push(b << 8, 1'b0, 1'b0, 1'b0);
      push((1 << 16) + (b << 8) + 1, 1'b1, 1'b0, 1'b0);
    end
    for (int r = 0; r < nq; r++) begin
      push((1 << 18) + (r << 8) + 2, 1'b1, 1'b0, 1'b0);
      push(r << 8, 1'b1, 1'b0, 1'b0);
      push((1 << 17) + (r << 8), 1'b1, 1'b0, 1'b0);
      push((1 << 19) + (r << 8) + 1, 1'b1, 1'b0, 1'b0);
    end
    push(0, 1'b1, 1'b0, 1'b1);
  endtask

  // Start a run (called just after a rising edge) and score it cycle by cycle.
  task automatic do_run(input bit sel, input int exp_len, input string nm);
    int cyc = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    rec_t r;
    logic [19:0] gi;
    logic gb, gd;
    if (sel) start_s = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_s = 1'b0;
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      cyc++;
      ofv   = r.ofv;
      start = r.inj;
      kwr   = r.inj;
      hadd  = r.inj ? 4'hA : 4'h0;
      @(negedge clk);
      gi = sel ? inst_s : inst;
      gb = sel ? busy_s : busy;
      gd = sel ? done_s : done;
      check($sformatf("%s inst cyc%0d", nm, cyc), 32'(gi), 32'(r.inst));
      check($sformatf("%s done cyc%0d", nm, cyc), 32'(gd), 32'(r.done));
      check($sformatf("%s busy cyc%0d", nm, cyc), 32'(gb), 32'd1);
      if (gd) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    kwr   = 1'b0;
    hadd  = 4'h0;
    ofv   = 1'b1;
    @(negedge clk);
    check({nm, " busy after"}, 32'(sel ? busy_s : busy), 32'd0);
    check({nm, " done after"}, 32'(sel ? done_s : done), 32'd0);
    check({nm, " inst after"}, 32'(sel ? inst_s : inst), 32'd0);
    check({nm, " done cycle"}, 32'(done_cyc), 32'(exp_len));
    check({nm, " done pulses"}, 32'(done_cnt), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{q:1'b1, k:1'b0, a:4'h5, st:1'b1, inst:20'h05010, busy:1'b0};
    vecs[1] = '{q:1'b0, k:1'b1, a:4'h3, st:1'b0, inst:20'h03004, busy:1'b0};
    vecs[2] = '{q:1'b1, k:1'b1, a:4'hF, st:1'b0, inst:20'h0F014, busy:1'b0};
    vecs[3] = '{q:1'b0, k:1'b0, a:4'h9, st:1'b0, inst:20'h09000, busy:1'b0};
    vecs[4] = '{q:1'b0, k:1'b1, a:4'h0, st:1'b1, inst:20'h00004, busy:1'b0};
    vecs[5] = '{q:1'b0, k:1'b0, a:4'h0, st:1'b0, inst:20'h00000, busy:1'b0};

    reset = 1'b0; start = 1'b0; start_s = 1'b0;
    qwr = 1'b0; kwr = 1'b0; hadd = 4'h0; ofv = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset inst",   32'(inst),   32'd0);
    check("reset busy",   32'(busy),   32'd0);
    check("reset done",   32'(done),   32'd0);
    check("reset inst_s", 32'(inst_s), 32'd0);
    check("reset busy_s", 32'(busy_s), 32'd0);
    check("reset done_s", 32'(done_s), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      qwr = vecs[i].q; kwr = vecs[i].k; hadd = vecs[i].a; start = vecs[i].st;
      @(posedge clk); #1;
      check($sformatf("idle vec%0d inst", i), 32'(inst), 32'(vecs[i].inst));
      check($sformatf("idle vec%0d busy", i), 32'(busy), 32'(vecs[i].busy));
    end
    qwr = 1'b0; kwr = 1'b0; hadd = 4'h0; start = 1'b0;
    @(posedge clk); #1;

    build(8, 8, 10, -1, 0, 1'b0);
    do_run(1'b0, 79, "default");

    build(8, 8, 10, 4, 3, 1'b0);
    do_run(1'b0, 82, "stall");

    build(8, 8, 10, -1, 0, 1'b1);
    do_run(1'b0, 79, "gap_inject");

    // Abort in the middle of EXEC step 3 (cycle 24 after start).
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (23) begin
      @(posedge clk); #1;
    end
    check("mid exec inst", 32'(inst), 32'h030A0);
    check("mid exec busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async reset inst", 32'(inst), 32'd0);
    check("async reset busy", 32'(busy), 32'd0);
    check("async reset done", 32'(done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    build(8, 8, 10, -1, 0, 1'b0);
    do_run(1'b0, 79, "post_reset");

    build(4, 2, 1, -1, 0, 1'b0);
    do_run(1'b1, 21, "small");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
